// File: rtl/data_cache.sv
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the CPU memory stage and a combinational-read, byte-addressed,
// little-endian data memory. A load miss stalls the CPU while the whole line
// is refilled one word per cycle. Stores always go straight to memory and
// update the cached copy only on a hit.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   REQ_VALID  CPU access request this cycle
//   REQ_WE     1 = store, 0 = load
//   REQ_A      byte address (bits [1:0] ignored)
//   REQ_WD     store data
//   RD         load data (valid when REQ_VALID && !REQ_WE && !STALL)
//   STALL      CPU must hold its request and freeze
//   MEM_A      word-aligned address to the data memory
//   MEM_WE     data memory write enable
//   MEM_WD     data memory write data
//   MEM_RD     combinational data memory read data
//   HIT_CNT    saturating load-hit counter
//   MISS_CNT   saturating load-miss counter
module data_cache #(
  parameter int A_WIDTH        = 28,
  parameter int SETS           = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  input  logic               REQ_WE,
  input  logic [A_WIDTH-1:0] REQ_A,
  input  logic [31:0]        REQ_WD,
  output logic [31:0]        RD,
  output logic               STALL,
  output logic [A_WIDTH-1:0] MEM_A,
  output logic               MEM_WE,
  output logic [31:0]        MEM_WD,
  input  logic [31:0]        MEM_RD,
  output logic [15:0]        HIT_CNT,
  output logic [15:0]        MISS_CNT
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = A_WIDTH - 2 - OFF_W - IDX_W;
  localparam int LINE_W  = A_WIDTH - 2 - OFF_W;   // tag + index
  localparam int WADDR_W = IDX_W + OFF_W;         // flat data-array index

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Saturating 16-bit increment used by both performance counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Registered state
  state_e              state_q, state_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;       // line address being refilled
  logic [SETS-1:0]     valid_q, valid_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  // Tag and data arrays (not reset)
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [31:0]         data_q [SETS*WORDS_PER_LINE];

  // Array write ports
  logic                data_we_s;
  logic [WADDR_W-1:0]  data_waddr_s;
  logic [31:0]         data_wdata_s;
  logic                tag_we_s;
  logic [IDX_W-1:0]    tag_widx_s;
  logic [TAG_W-1:0]    tag_wdata_s;

  // Request address decode
  logic [OFF_W-1:0]    req_off_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic [LINE_W-1:0]   req_line_s;
  logic [A_WIDTH-1:0]  req_aligned_s;
  logic                hit_s;
  logic [IDX_W-1:0]    fill_idx_s;
  logic [TAG_W-1:0]    fill_tag_s;

  assign req_off_s     = REQ_A[2 +: OFF_W];
  assign req_idx_s     = REQ_A[2+OFF_W +: IDX_W];
  assign req_tag_s     = REQ_A[A_WIDTH-1 -: TAG_W];
  assign req_line_s    = REQ_A[A_WIDTH-1 -: LINE_W];
  assign req_aligned_s = {REQ_A[A_WIDTH-1:2], 2'b00};
  assign hit_s         = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign fill_idx_s    = line_q[IDX_W-1:0];
  assign fill_tag_s    = line_q[LINE_W-1:IDX_W];

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;

  // Next-state, CPU/memory outputs and array write ports.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    valid_d      = valid_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    RD           = 32'h0000_0000;
    STALL        = 1'b0;
    MEM_A        = req_aligned_s;
    MEM_WE       = 1'b0;
    MEM_WD       = REQ_WD;
    data_we_s    = 1'b0;
    data_waddr_s = {req_idx_s, req_off_s};
    data_wdata_s = REQ_WD;
    tag_we_s     = 1'b0;
    tag_widx_s   = fill_idx_s;
    tag_wdata_s  = fill_tag_s;

    if (RST) begin
      // Outputs stay at their quiet defaults; state is cleared in the flops.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            if (REQ_WE) begin
              // Write-through; update the cached copy only when resident.
              MEM_WE    = 1'b1;
              data_we_s = hit_s;
            end else if (hit_s) begin
              RD        = data_q[{req_idx_s, req_off_s}];
              hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
              STALL      = 1'b1;
              miss_cnt_d = sat_inc(miss_cnt_q);
              line_d     = req_line_s;
              cnt_d      = '0;
              state_d    = REFILL;
            end
          end else begin
            state_d = IDLE;
          end
        end

        REFILL: begin
          // Inputs are ignored; the refill always runs to completion.
          STALL        = 1'b1;
          MEM_A        = {line_q, cnt_q, 2'b00};
          data_we_s    = 1'b1;
          data_waddr_s = {fill_idx_s, cnt_q};
          data_wdata_s = MEM_RD;
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            valid_d[fill_idx_s] = 1'b1;
            tag_we_s            = 1'b1;
            cnt_d               = '0;
            state_d             = IDLE;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control state and counters, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays; write ports are already gated off during reset.
  always_ff @(posedge CLK) begin
    if (data_we_s) begin
      data_q[data_waddr_s] <= data_wdata_s;
    end
    if (tag_we_s) begin
      tag_q[tag_widx_s] <= tag_wdata_s;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  localparam int AW  = 28;
  localparam int WPL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_we;
  logic [AW-1:0]   req_a;
  logic [31:0]     req_wd;
  logic [31:0]     rd;
  logic            stall;
  logic [AW-1:0]   mem_a;
  logic            mem_we;
  logic [31:0]     mem_wd;
  logic [31:0]     mem_rd;
  logic [15:0]     hit_cnt;
  logic [15:0]     miss_cnt;

  always #5 clk = ~clk;

  data_cache #(.A_WIDTH(AW), .SETS(8), .WORDS_PER_LINE(WPL)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_WE(req_we),
    .REQ_A(req_a), .REQ_WD(req_wd), .RD(rd), .STALL(stall),
    .MEM_A(mem_a), .MEM_WE(mem_we), .MEM_WD(mem_wd), .MEM_RD(mem_rd),
    .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt)
  );

  // Every address the bench uses has only bits [19:16] and [11:2] set,
  // so this 14-bit word index is unique per address.
  function automatic int unsigned midx(input logic [AW-1:0] a);
    logic [13:0] i;
    i = {a[19:16], a[11:2]};
    return int'(i);
  endfunction

  // Initial memory image: 0x10000..0x1000C hold 0x11..0x44, rest is hashed.
  function automatic logic [31:0] init_word(input int unsigned i);
    if (i >= 32'h400 && i <= 32'h403) return 32'h11 * (i - 32'h400 + 32'd1);
    return (i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // ---------------- data memory presented to the DUT ----------------
  logic [31:0] phys_mem [16384];
  bit          phys_wr  [16384];
  logic [13:0] mem_idx;
  assign mem_idx = {mem_a[19:16], mem_a[11:2]};
  assign mem_rd  = phys_wr[mem_idx] ? phys_mem[mem_idx] : init_word(32'(mem_idx));

  always @(posedge clk) begin
    if (mem_we) begin
      phys_mem[mem_idx] <= mem_wd;
      phys_wr[mem_idx]  <= 1'b1;
    end
  end

  // ---------------- reference model (driver side) ----------------
  logic [31:0] ref_mem [16384];
  bit          ref_wr  [16384];
  bit          m_valid [8];
  int unsigned m_tag   [8];
  int unsigned m_hit, m_miss;

  function automatic int unsigned sat(input int unsigned v);
    return (v >= 32'd65535) ? 32'd65535 : v + 32'd1;
  endfunction

  typedef enum int {K_ACC, K_RST, K_POST} kind_e;
  typedef struct {
    kind_e       kind;
    bit          we;
    logic [AW-1:0] addr;
    logic [31:0] data;
    int          stalls;
    logic [15:0] hit;
    logic [15:0] miss;
  } exp_t;

  exp_t q[$];
  bit   mon_en      = 1'b0;
  bit   drv_timeout = 1'b0;

  // ---------------- monitor / scoreboard ----------------
  int checks    = 0;
  int errors    = 0;
  int stall_run = 0;
  bit timeout_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (drv_timeout && !timeout_seen) begin
      timeout_seen = 1'b1;
      chk("request_timeout", 32'(drv_timeout), 32'd0);
    end
    if (q.size() > 0 && q[0].kind != K_ACC) begin
      e = q.pop_front();
      chk("rst_stall",  32'(stall),  32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rd",     rd,          32'd0);
      if (e.kind == K_POST) begin
        chk("hit_cnt",  32'(hit_cnt),  32'(e.hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
      end
      stall_run = 0;
    end else if (!mon_en) begin
      stall_run = 0;
    end else if (req_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_request", 32'd1, 32'd0);
      end else if (stall) begin
        e = q[0];
        if (stall_run >= 1) begin
          chk("refill_mem_a",  32'(mem_a),
              32'({e.addr[AW-1:4], 4'h0}) + 32'(4 * (stall_run - 1)));
          chk("refill_mem_we", 32'(mem_we), 32'd0);
        end
        stall_run++;
      end else begin
        e = q.pop_front();
        chk("stall_cycles", 32'(stall_run), 32'(e.stalls));
        if (e.we) begin
          chk("store_mem_we", 32'(mem_we), 32'd1);
          chk("store_mem_a",  32'(mem_a),  32'(e.addr));
          chk("store_mem_wd", mem_wd,      e.data);
        end else begin
          chk("load_rd",     rd,          e.data);
          chk("load_mem_we", 32'(mem_we), 32'd0);
        end
        chk("hit_cnt",  32'(hit_cnt),  32'(e.hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
        stall_run = 0;
      end
    end else begin
      chk("idle_stall",  32'(stall),  32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_rd",     rd,          32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
  endtask

  task automatic push_check(input kind_e k);
    exp_t e;
    e = '{kind: k, we: 1'b0, addr: '0, data: 32'd0, stalls: 0,
          hit: 16'(m_hit), miss: 16'(m_miss)};
    q.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [31:0] wd);
    exp_t        e;
    int unsigned s, t, wi;
    bit          done;
    s  = int'(a[6:4]);
    t  = int'(a[AW-1:7]);
    wi = midx(a);
    e.kind = K_ACC;
    e.we   = we;
    e.addr = {a[AW-1:2], 2'b00};
    if (we) begin
      ref_mem[wi] = wd;
      ref_wr[wi]  = 1'b1;
      e.data   = wd;
      e.stalls = 0;
      e.hit    = 16'(m_hit);
      e.miss   = 16'(m_miss);
    end else begin
      if (m_valid[s] && m_tag[s] == t) begin
        e.stalls = 0;
      end else begin
        e.stalls   = WPL + 1;
        m_miss     = sat(m_miss);
        m_valid[s] = 1'b1;
        m_tag[s]   = t;
      end
      e.data = ref_wr[wi] ? ref_mem[wi] : init_word(wi);
      e.hit  = 16'(m_hit);
      e.miss = 16'(m_miss);
      m_hit  = sat(m_hit);
    end
    q.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_a     = a;
    req_wd    = wd;
    done      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!done) begin
        @(negedge clk);
        done = !stall;
      end
    end
    if (!done) drv_timeout = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_a     = AW'($urandom);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_a     = AW'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [3:0] hi;
    logic [7:0] lo;
    hi = 4'($urandom_range(1, 2));
    lo = 8'($urandom_range(0, 255));
    return {8'h00, hi, 4'h0, 2'b00, lo, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_a     = '0;
    req_wd    = 32'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    push_check(K_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_check(K_POST);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed scenarios
    issue(1'b0, 28'h0010000, 32'd0);          // miss + refill, returns 0x11
    issue(1'b0, 28'h0010008, 32'd0);          // same-line hit, 0x33
    issue(1'b1, 28'h0010004, 32'hDEADBEEF);   // store hit
    issue(1'b0, 28'h0010004, 32'd0);          // hit with updated word
    issue(1'b1, 28'h0020000, 32'h12345678);   // store miss, no allocate
    issue(1'b0, 28'h0020000, 32'd0);          // miss, returns stored value
    issue(1'b0, 28'h0010080, 32'd0);          // conflict eviction
    issue(1'b0, 28'h0010000, 32'd0);          // misses again
    idle(2);

    // Reset during the second refill cycle of a missing load
    mon_en    = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_a     = 28'h0030000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    push_check(K_RST);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    push_check(K_POST);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(1'b0, 28'h0010000, 32'd0);          // full miss after reset
    issue(1'b0, 28'h0030000, 32'd0);          // aborted line stayed invalid

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 9) < 3), rand_addr(), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(1);
    push_check(K_POST);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
